if_fetch_queue: RTL and testbench

Parametrised IF-stage successor to the single-entry IF pipeline register. It sits between PREIF and ID. It accepts PCs from PREIF with a valid/ready handshake and issues in-order instruction requests on the CPU I-bus. It holds up to DEPTH fetches, in flight or completed, in a circular queue and presents completed {PC, instruction, exception type} to ID in program order. On flush it discards every queued entry and silently drops I-bus responses still outstanding.

---
 rtl/if_fetch_queue.sv | 191 +++++++++++++++++++
 tb/tb_if_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// IF-stage fetch queue: accepts PCs from PREIF, issues in-order I-bus requests,
// and hands completed {pc, instr, except} entries to ID in program order.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int EXC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             preif_valid,
    output logic             preif_ready,
    input  logic [XLEN-1:0]  preif_pc,
    input  logic [EXC_W-1:0] preif_except,
    output logic             ibus_req,
    output logic [XLEN-1:0]  ibus_addr,
    input  logic             ibus_addr_ok,
    input  logic             ibus_data_ok,
    input  logic [XLEN-1:0]  ibus_rdata,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_instr,
    output logic [EXC_W-1:0] id_except
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t CNT_MAX = cnt_t'(DEPTH);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] done_reg;
    logic [XLEN-1:0]  pc_reg     [DEPTH];
    logic [XLEN-1:0]  instr_reg  [DEPTH];
    logic [EXC_W-1:0] except_reg [DEPTH];

    ptr_t head_reg, head_next;
    ptr_t alloc_reg, alloc_next;
    ptr_t resp_reg, resp_next;
    cnt_t count_reg, count_next;
    cnt_t inflight_reg, inflight_next;
    cnt_t drop_cnt_reg, drop_cnt_next;

    logic          full;
    logic          is_exc;
    logic          room;
    logic          cap_ok;
    logic [CW:0]   outstanding;
    logic          push_normal;
    logic          push_exc;
    logic          push;
    logic          pop;
    logic          fill;
    logic          drop_dec;

    logic [DEPTH-1:0] push_sel;
    logic [DEPTH-1:0] fill_sel;
    logic [DEPTH-1:0] pop_sel;

    assign full        = (count_reg == CNT_MAX);
    assign is_exc      = |preif_except;
    assign room        = preif_valid & ~full & ~flush & ~rst;
    // Stale responses still occupy the bus, so they count against the cap.
    assign outstanding = {1'b0, inflight_reg} + {1'b0, drop_cnt_reg};
    assign cap_ok      = (outstanding < {1'b0, CNT_MAX});

    assign ibus_req    = room & ~is_exc & cap_ok;
    assign ibus_addr   = preif_pc;
    assign push_normal = ibus_req & ibus_addr_ok;
    assign push_exc    = room & is_exc & (inflight_reg == '0);
    assign push        = push_normal | push_exc;
    assign preif_ready = push;

    assign id_valid  = ~rst & valid_reg[head_reg] & done_reg[head_reg];
    assign id_pc     = pc_reg[head_reg];
    assign id_instr  = instr_reg[head_reg];
    assign id_except = except_reg[head_reg];

    assign pop      = id_valid & id_ready & ~flush;
    assign drop_dec = ibus_data_ok & (drop_cnt_reg != '0);
    // A response with nothing outstanding is a protocol error and is ignored.
    assign fill     = ibus_data_ok & ~flush & (drop_cnt_reg == '0) & (inflight_reg != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
        assign push_sel[gi] = push & (alloc_reg == ptr_t'(gi));
        assign fill_sel[gi] = fill & (resp_reg  == ptr_t'(gi));
        assign pop_sel[gi]  = pop  & (head_reg  == ptr_t'(gi));
    end

    always_comb begin
        head_next     = head_reg;
        alloc_next    = alloc_reg;
        resp_next     = resp_reg;
        count_next    = count_reg;
        inflight_next = inflight_reg;
        drop_cnt_next = drop_cnt_reg;
        if (flush) begin
            head_next     = '0;
            alloc_next    = '0;
            resp_next     = '0;
            count_next    = '0;
            inflight_next = '0;
            if (ibus_data_ok && (drop_cnt_reg != '0 || inflight_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg + inflight_reg - CNT_ONE;
            end else begin
                drop_cnt_next = drop_cnt_reg + inflight_reg;
            end
        end else begin
            if (push) begin
                alloc_next = alloc_reg + PTR_ONE;
            end
            // Exception entries are born complete, so resp must skip over them.
            if ((push_exc && resp_reg == alloc_reg) || fill) begin
                resp_next = resp_reg + PTR_ONE;
            end
            if (pop) begin
                head_next = head_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
            case ({push_normal, fill})
                2'b10:   inflight_next = inflight_reg + CNT_ONE;
                2'b01:   inflight_next = inflight_reg - CNT_ONE;
                default: inflight_next = inflight_reg;
            endcase
            if (drop_dec) begin
                drop_cnt_next = drop_cnt_reg - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            alloc_reg    <= '0;
            resp_reg     <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            head_reg     <= head_next;
            alloc_reg    <= alloc_next;
            resp_reg     <= resp_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_reg <= '0;
            done_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_sel[i]) begin
                    valid_reg[i] <= 1'b1;
                    done_reg[i]  <= push_exc;
                end else if (fill_sel[i]) begin
                    done_reg[i]  <= 1'b1;
                end else if (pop_sel[i]) begin
                    valid_reg[i] <= 1'b0;
                    done_reg[i]  <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: valid/done gate every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_sel[i]) begin
                pc_reg[i]     <= preif_pc;
                except_reg[i] <= preif_except;
                instr_reg[i]  <= '0;
            end else if (fill_sel[i]) begin
                instr_reg[i]  <= ibus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: fetch streaming, full queue, flush with
// stale responses, exception entries and mid-stream reset.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        preif_valid;
    logic        preif_ready;
    logic [31:0] preif_pc;
    logic [31:0] preif_except;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [31:0] ibus_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_except;

    int total_cnt = 0;
    int bad_cnt   = 0;

    if_fetch_queue #(.DEPTH(4), .XLEN(32), .EXC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .preif_valid  (preif_valid),
        .preif_ready  (preif_ready),
        .preif_pc     (preif_pc),
        .preif_except (preif_except),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_addr_ok (ibus_addr_ok),
        .ibus_data_ok (ibus_data_ok),
        .ibus_rdata   (ibus_rdata),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_except    (id_except)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && !flush && id_valid && id_ready)
            $display("pop pc=%08h instr=%08h except=%08h", id_pc, id_instr, id_except);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] exc,
                       input logic aok, input logic dok, input logic [31:0] rd,
                       input logic rdy);
        preif_valid  = v;
        preif_pc     = pc;
        preif_except = exc;
        ibus_addr_ok = aok;
        ibus_data_ok = dok;
        ibus_rdata   = rd;
        id_ready     = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drv(1'b1, 32'h1234, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        chk("rst_ready", 32'(preif_ready), 32'h0);
        chk("rst_req",   32'(ibus_req),    32'h0);
        chk("rst_idv",   32'(id_valid),    32'h0);
        tick();
        rst = 1'b0;

        // Back-to-back fetch with one-cycle response latency
        drv(1'b1, 32'hBFC00000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
        chk("b2b_req0",   32'(ibus_req),    32'h1);
        chk("b2b_ready0", 32'(preif_ready), 32'h1);
        chk("b2b_addr0",  ibus_addr,        32'hBFC00000);
        chk("b2b_idv0",   32'(id_valid),    32'h0);
        tick();
        drv(1'b1, 32'hBFC00004, 32'h0, 1'b1, 1'b1, 32'h1111, 1'b1); #1;
        chk("b2b_ready1", 32'(preif_ready), 32'h1);
        chk("b2b_idv1",   32'(id_valid),    32'h0);
        tick();
        drv(1'b1, 32'hBFC00008, 32'h0, 1'b1, 1'b1, 32'h2222, 1'b1); #1;
        chk("b2b_idv2",   32'(id_valid), 32'h1);
        chk("b2b_pc2",    id_pc,         32'hBFC00000);
        chk("b2b_ins2",   id_instr,      32'h1111);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3333, 1'b1); #1;
        chk("b2b_idv3",   32'(id_valid), 32'h1);
        chk("b2b_pc3",    id_pc,         32'hBFC00004);
        chk("b2b_ins3",   id_instr,      32'h2222);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
        chk("b2b_idv4",   32'(id_valid), 32'h1);
        chk("b2b_pc4",    id_pc,         32'hBFC00008);
        chk("b2b_ins4",   id_instr,      32'h3333);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
        chk("b2b_empty",  32'(id_valid), 32'h0);
        tick();

        // Full queue: four accepted, fifth blocked until after the first pop
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 32'h100 + 32'(4 * k), 32'h0, 1'b1, (k != 0), 32'hA00 + 32'(k) - 32'h1, 1'b0); #1;
            chk("full_acc", 32'(preif_ready), 32'h1);
            tick();
        end
        drv(1'b1, 32'h110, 32'h0, 1'b1, 1'b1, 32'hA03, 1'b0); #1;
        chk("full_ready5", 32'(preif_ready), 32'h0);
        chk("full_req5",   32'(ibus_req),    32'h0);
        chk("full_pc0",    id_pc,            32'h100);
        tick();
        drv(1'b1, 32'h110, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
        chk("full_poppush", 32'(preif_ready), 32'h0);
        chk("full_ins0",    id_instr,         32'hA00);
        tick();
        drv(1'b1, 32'h110, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("full_after",   32'(preif_ready), 32'h1);
        chk("full_pc1",     id_pc,            32'h104);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA04, 1'b1); #1;
        chk("drain_pc1",  id_pc,    32'h104);
        chk("drain_ins1", id_instr, 32'hA01);
        tick();
        for (int j = 2; j < 5; j++) begin
            drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
            chk("drain_idv", 32'(id_valid), 32'h1);
            chk("drain_pc",  id_pc,         32'h100 + 32'(4 * j));
            chk("drain_ins", id_instr,      32'hA00 + 32'(j));
            tick();
        end
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
        chk("drain_empty", 32'(id_valid), 32'h0);
        tick();

        // Flush with three outstanding requests
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 32'h200 + 32'(4 * k), 32'h0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
            chk("fl_acc", 32'(preif_ready), 32'h1);
            tick();
        end
        flush = 1'b1;
        drv(1'b1, 32'h80000000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
        chk("fl_ready", 32'(preif_ready), 32'h0);
        chk("fl_req",   32'(ibus_req),    32'h0);
        tick();
        flush = 1'b0;
        drv(1'b1, 32'h80000000, 32'h0, 1'b1, 1'b1, 32'hDEAD, 1'b0); #1;
        chk("fl_drop3",  32'(dut.drop_cnt_reg), 32'h3);
        chk("fl_resume", 32'(preif_ready),      32'h1);
        chk("fl_idv_a",  32'(id_valid),         32'h0);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b0); #1;
        chk("fl_drop2",  32'(dut.drop_cnt_reg), 32'h2);
        chk("fl_idv_b",  32'(id_valid),         32'h0);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b0); #1;
        chk("fl_drop1",  32'(dut.drop_cnt_reg), 32'h1);
        chk("fl_idv_c",  32'(id_valid),         32'h0);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4444, 1'b0); #1;
        chk("fl_drop0",  32'(dut.drop_cnt_reg), 32'h0);
        chk("fl_idv_d",  32'(id_valid),         32'h0);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
        chk("fl_idv",    32'(id_valid), 32'h1);
        chk("fl_pc",     id_pc,         32'h80000000);
        chk("fl_ins",    id_instr,      32'h4444);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
        chk("fl_empty",  32'(id_valid), 32'h0);
        tick();

        // Exception PC behind an in-flight normal fetch
        drv(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("ex_acc_n", 32'(preif_ready), 32'h1);
        tick();
        drv(1'b1, 32'h80000001, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("ex_wait_r0", 32'(preif_ready), 32'h0);
        chk("ex_wait_q0", 32'(ibus_req),    32'h0);
        tick();
        drv(1'b1, 32'h80000001, 32'h10, 1'b1, 1'b1, 32'h5555, 1'b0); #1;
        chk("ex_wait_r1", 32'(preif_ready), 32'h0);
        tick();
        drv(1'b1, 32'h80000001, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("ex_acc",    32'(preif_ready), 32'h1);
        chk("ex_noreq",  32'(ibus_req),    32'h0);
        chk("ex_head_v", 32'(id_valid),    32'h1);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
        chk("ex_n_pc",   id_pc,     32'h300);
        chk("ex_n_ins",  id_instr,  32'h5555);
        chk("ex_n_exc",  id_except, 32'h0);
        tick();
        #1;
        chk("ex_e_v",    32'(id_valid), 32'h1);
        chk("ex_e_pc",   id_pc,         32'h80000001);
        chk("ex_e_ins",  id_instr,      32'h0);
        chk("ex_e_exc",  id_except,     32'h10);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
        chk("ex_empty",  32'(id_valid), 32'h0);
        tick();

        // Flush coinciding with a response, two in flight
        for (int k = 0; k < 2; k++) begin
            drv(1'b1, 32'h400 + 32'(4 * k), 32'h0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
            chk("fd_acc", 32'(preif_ready), 32'h1);
            tick();
        end
        flush = 1'b1;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b0); #1;
        tick();
        flush = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b0); #1;
        chk("fd_drop1", 32'(dut.drop_cnt_reg), 32'h1);
        chk("fd_idv0",  32'(id_valid),         32'h0);
        tick();
        drv(1'b1, 32'h408, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("fd_drop0", 32'(dut.drop_cnt_reg), 32'h0);
        chk("fd_idv1",  32'(id_valid),         32'h0);
        chk("fd_acc2",  32'(preif_ready),      32'h1);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h6666, 1'b0); #1;
        chk("fd_idv2",  32'(id_valid), 32'h0);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
        chk("fd_pc",    id_pc,    32'h408);
        chk("fd_ins",   id_instr, 32'h6666);
        tick();

        // Reset in the middle of a stream with two complete entries
        drv(1'b1, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
        tick();
        drv(1'b1, 32'h504, 32'h0, 1'b1, 1'b1, 32'h7777, 1'b0); #1;
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8888, 1'b0); #1;
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
        chk("mr_pre_pc", id_pc, 32'h500);
        tick();
        rst = 1'b1;
        drv(1'b1, 32'h600, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
        chk("mr_idv",   32'(id_valid),    32'h0);
        chk("mr_ready", 32'(preif_ready), 32'h0);
        chk("mr_req",   32'(ibus_req),    32'h0);
        tick();
        rst = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
        chk("mr_empty", 32'(id_valid), 32'h0);
        tick();
        drv(1'b1, 32'h700, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
        chk("mr_acc",   32'(preif_ready), 32'h1);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h9999, 1'b1); #1;
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
        chk("mr_pc",    id_pc,    32'h700);
        chk("mr_ins",   id_instr, 32'h9999);
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
